spi_rx_packer: RTL and testbench
================================

# spi_rx_packer

Parametrised SPI master receive engine with integrated packet FIFO, all in the `m_clk` domain. On a `start` pulse it asserts `spi_cs` and generates `spi_clk` in any of the four CPOL/CPHA modes. It shifts out one command word on `spi_mosi_out` and captures `WORDS` words of `DATA_W` bits from `spi_miso_in`. Each packet is pushed into a `FIFO_DEPTH`-entry buffer, which the host drains one packet per `read_req`.

## Interface
- `DATA_W`, 8, bits per SPI word (≥2)
- `WORDS`, 15, words per packet; packet width `PKT_W = DATA_W*WORDS` (default 120)
- `CLK_DIV`, 4, `spi_clk` half-period in `m_clk` cycles (≥2)
- `FIFO_DEPTH`, 4, packet entries, power of two (≥2)

Ports (one clock, `m_clk`; reset `n_reset` is asynchronous, active-low):
- `m_clk`  in  1  system clock
- `n_reset`  in  1  async active-low reset
- `start`  in  1  single-cycle request to capture one packet
- `cpol`, `cpha`  in  1 each  SPI mode, latched on accepted `start`
- `cmd`  in  DATA_W  command word, latched on accepted `start`
- `spi_clk`  out  1  SPI clock
- `spi_cs`  out  1  chip select, active-low
- `spi_mosi_out`  out  1  master data out
- `spi_miso_in`  in  1  slave data in
- `busy`  out  1  transfer in progress
- `read_req`  in  1  pop one packet
- `data_out`  out  PKT_W  last popped packet; first received word in the MS bits
- `data_valid`  out  1  one-cycle pulse when `data_out` is updated
- `fifo_empty`, `fifo_full`  out  1 each  FIFO status
- `overflow`  out  1  sticky; a packet was dropped

## Operation
- FSM states:
  - IDLE: `spi_cs`=1, `spi_clk`=`cpol_q`. An accepted `start` (in IDLE only) latches `cpol`, `cpha` and `cmd`, then goes to LEAD. `start` in any other state is ignored.
  - LEAD: `spi_cs`=0 for `CLK_DIV` cycles, then SHIFT.
  - SHIFT: `spi_clk` toggles every `CLK_DIV` cycles, for `2*PKT_W` edges in total. Odd edges are leading; even edges are trailing. At the last edge → TRAIL.
  - TRAIL: hold `spi_cs`=0 and `spi_clk`=`cpol_q` for `CLK_DIV` cycles, then PUSH.
  - PUSH: one cycle. Write the packet to the FIFO, or set `overflow` if full; → IDLE.
- Sampling:
  - `cpha`=0: `spi_miso_in` is registered on the `m_clk` edge that produces a leading edge. MOSI updates on trailing edges; the first bit is driven on LEAD entry.
  - `cpha`=1: MOSI updates on leading edges and MISO is sampled on trailing edges.
- MOSI: during word 0 it sends `cmd_q`, bit order per Configuration. It is 0 for all later words and 0 in IDLE.
- Word assembly: each word shifts into a `DATA_W` register. Completed words are concatenated so that word 0 lands in `[PKT_W-1 -: DATA_W]`.
- FIFO:
  - Binary read/write pointers with an extra wrap bit. Full is when the pointers differ only in the MSB.
  - `read_req` while empty is ignored: no pulse, `data_out` holds.
  - A PUSH and a `read_req` in the same cycle while full both succeed with no overflow (pop first).
- `busy` = (state != IDLE).

## Timing
- Reset values: `spi_cs`=1, `spi_clk`=0, `spi_mosi_out`=0, `busy`=0, `data_out`=0, `data_valid`=0, `fifo_empty`=1, `fifo_full`=0, `overflow`=0, `cpol_q`=0, state IDLE.
- Reset asserted mid-transfer: all of the above apply immediately, the partial packet is discarded and FIFO contents are lost.
- `start` at cycle T → `spi_cs` falls at T+1. The first `spi_clk` edge occurs at T+1+`CLK_DIV`.
- Transfer length, `start` to PUSH: 1 + `CLK_DIV`*(2*PKT_W+2) cycles. `fifo_empty` deasserts the cycle after PUSH.
- `read_req` at cycle R → `data_out` and `data_valid`=1 at R+1. Back-to-back reads are supported, one per cycle.
- `spi_clk` period = 2*`CLK_DIV` `m_clk` cycles, 50% duty.
- All outputs are registered.

## Configuration
- `SPI_RX_LSB_FIRST_EN`:
  - Defined: both MOSI and MISO words are LSB first, so the first received bit lands in bit 0 of its word.
  - Undefined (default): MSB first.
  - Packet word ordering is unaffected in both cases.

## Test plan
- Mode 0, `CLK_DIV`=4, MISO model returns 0x01..0x0F, one `start`, then `read_req` → `data_out`=0x0102…0F, `data_valid` pulses once, `spi_cs` is low for 4*(240+2)=968 cycles.
- Modes 1/2/3 with the same slave model → identical `data_out`; idle `spi_clk` level equals `cpol`. MOSI carries `cmd`=0xA5 MSB first, then zeros.
- Five packets with no reads (`FIFO_DEPTH`=4) → `fifo_full`=1 after the 4th, `overflow`=1 after the 5th. Four reads return packets 1–4 in order, then `fifo_empty`=1.
- FIFO full, `read_req` asserted in the PUSH cycle → no overflow, `fifo_full` stays 1.
- Drop `n_reset` mid-SHIFT → `spi_cs`=1, `busy`=0, `fifo_empty`=1 immediately. `start` after release completes a correct packet.
- Build with `SPI_RX_LSB_FIRST_EN`, slave sends 0x01 LSB first → word reads 0x01, and `cmd` 0x80 appears on MOSI with its 1 in the last bit slot.

Source files
------------

// File: rtl/spi_rx_packer.sv
// spi_rx_packer: SPI master receive engine with an integrated packet FIFO.
// A start pulse opens one chip-select window. Within it one command word is
// shifted out on MOSI and WORDS words are captured from MISO. The assembled
// packet is then pushed into a FIFO_DEPTH-entry buffer that the host drains
// one packet per read_req. All four CPOL/CPHA modes are supported.
// Optional build macro: SPI_RX_LSB_FIRST_EN selects LSB-first words on both
// MOSI and MISO. When it is undefined, words are MSB first.
module spi_rx_packer #(
  parameter int DATA_W     = 8,
  parameter int WORDS      = 15,
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      m_clk,
  input  logic                      n_reset,
  input  logic                      start,
  input  logic                      cpol,
  input  logic                      cpha,
  input  logic [DATA_W-1:0]         cmd,
  output logic                      spi_clk,
  output logic                      spi_cs,
  output logic                      spi_mosi_out,
  input  logic                      spi_miso_in,
  output logic                      busy,
  input  logic                      read_req,
  output logic [DATA_W*WORDS-1:0]   data_out,
  output logic                      data_valid,
  output logic                      fifo_empty,
  output logic                      fifo_full,
  output logic                      overflow
);

  localparam int PKT_W = DATA_W * WORDS;
  localparam int EDGES = 2 * PKT_W;
  localparam int EW    = $clog2(EDGES + 1);
  localparam int DW    = $clog2(CLK_DIV);
  localparam int BW    = $clog2(DATA_W);
  localparam int AW    = $clog2(FIFO_DEPTH);

  localparam logic [DW-1:0] DIV_LD   = DW'(CLK_DIV - 1);
  localparam logic [EW-1:0] EDGE_END = EW'(EDGES);
  localparam logic [BW-1:0] BIT_END  = BW'(DATA_W - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEAD  = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_TRAIL = 3'd3;
  localparam logic [2:0] S_PUSH  = 3'd4;

  // Returns the next bit to drive from the transmit shift register.
  function automatic logic f_tx_bit(input logic [DATA_W-1:0] v);
`ifdef SPI_RX_LSB_FIRST_EN
    return v[0];
`else
    return v[DATA_W-1];
`endif
  endfunction

  // Advances the transmit register by one bit. It fills with zeros, so MOSI
  // reads 0 once the command word has been sent.
  function automatic logic [DATA_W-1:0] f_tx_shift(input logic [DATA_W-1:0] v);
`ifdef SPI_RX_LSB_FIRST_EN
    return v >> 1;
`else
    return v << 1;
`endif
  endfunction

  // Shifts one received bit into a word. In both orders the first bit
  // received ends in its proper position after DATA_W shifts.
  function automatic logic [DATA_W-1:0] f_rx_shift(input logic [DATA_W-1:0] w,
                                                   input logic b);
`ifdef SPI_RX_LSB_FIRST_EN
    return {b, w[DATA_W-1:1]};
`else
    return {w[DATA_W-2:0], b};
`endif
  endfunction

  // Control state
  logic [2:0]        r_state;
  logic [DW-1:0]     r_div;
  logic [EW-1:0]     r_edge;
  logic [BW-1:0]     r_bit;
  logic              r_cs;
  logic              r_clk;
  logic              r_busy;
  logic              r_cpol;
  logic              r_cpha;
  logic              r_mosi;

  // Datapath registers (no reset needed: always loaded before use)
  logic [DATA_W-1:0] r_tx;
  logic [DATA_W-1:0] r_word;
  logic [PKT_W-1:0]  r_pkt;

  // FIFO
  logic [PKT_W-1:0]  r_mem [FIFO_DEPTH];
  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic              r_empty;
  logic              r_full;
  logic              r_ovf;
  logic [PKT_W-1:0]  r_dout;
  logic              r_dvalid;

  // Edge and FIFO decode
  logic              w_fire;
  logic [EW-1:0]     w_edge_num;
  logic              w_leading;
  logic              w_sample;
  logic              w_tx_upd;
  logic [DATA_W-1:0] w_word_nxt;
  logic              w_word_done;
  logic              w_push_req;
  logic              w_pop;
  logic              w_push;
  logic [AW:0]       w_wr_nxt;
  logic [AW:0]       w_rd_nxt;

  // Decode which SPI edge (if any) this cycle produces and what it does.
  // The first edge is produced on the LEAD-to-SHIFT transition.
  always_comb begin
    w_fire     = 1'b0;
    w_edge_num = r_edge + EW'(1);
    if (r_state == S_LEAD) begin
      w_edge_num = EW'(1);
      w_fire     = (r_div == '0);
    end else if (r_state == S_SHIFT) begin
      w_fire     = (r_div == '0) && (r_edge != EDGE_END);
    end
    w_leading   = w_edge_num[0];
    // cpha=0 samples on leading edges and shifts MOSI on trailing edges.
    // cpha=1 does the opposite.
    w_sample    = w_fire && (w_leading ^ r_cpha);
    w_tx_upd    = w_fire && !(w_leading ^ r_cpha);
    w_word_nxt  = f_rx_shift(r_word, spi_miso_in);
    w_word_done = (r_bit == BIT_END);
  end

  // FIFO pointer arithmetic. A pop is taken first, so a push into a full
  // FIFO succeeds when a read happens in the same cycle.
  always_comb begin
    w_push_req = (r_state == S_PUSH);
    w_pop      = read_req && !r_empty;
    w_push     = w_push_req && (!r_full || w_pop);
    w_wr_nxt   = r_wr_ptr + {{AW{1'b0}}, w_push};
    w_rd_nxt   = r_rd_ptr + {{AW{1'b0}}, w_pop};
  end

  // Transfer sequencing: chip select, SPI clock, MOSI and bit counting.
  always_ff @(posedge m_clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state <= S_IDLE;
      r_div   <= '0;
      r_edge  <= '0;
      r_bit   <= '0;
      r_cs    <= 1'b1;
      r_clk   <= 1'b0;
      r_busy  <= 1'b0;
      r_cpol  <= 1'b0;
      r_cpha  <= 1'b0;
      r_mosi  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_LEAD;
            r_div   <= DIV_LD;
            r_edge  <= '0;
            r_bit   <= '0;
            r_cs    <= 1'b0;
            r_busy  <= 1'b1;
            r_cpol  <= cpol;
            r_cpha  <= cpha;
            r_clk   <= cpol;
            // In cpha=0 the first bit must be valid before the first edge.
            r_mosi  <= cpha ? 1'b0 : f_tx_bit(cmd);
          end
        end
        S_LEAD: begin
          if (r_div == '0) begin
            r_state <= S_SHIFT;
            r_div   <= DIV_LD;
            r_clk   <= ~r_clk;
            r_edge  <= EW'(1);
          end else begin
            r_div   <= r_div - DW'(1);
          end
        end
        S_SHIFT: begin
          if (r_div == '0) begin
            r_div <= DIV_LD;
            if (r_edge == EDGE_END) begin
              // The last half-period has elapsed. SPI clock is back at CPOL.
              r_state <= S_TRAIL;
              r_mosi  <= 1'b0;
            end else begin
              r_clk  <= ~r_clk;
              r_edge <= w_edge_num;
            end
          end else begin
            r_div <= r_div - DW'(1);
          end
        end
        S_TRAIL: begin
          if (r_div == '0) begin
            r_state <= S_PUSH;
            r_cs    <= 1'b1;
          end else begin
            r_div   <= r_div - DW'(1);
          end
        end
        S_PUSH: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_cs    <= 1'b1;
          r_busy  <= 1'b0;
          r_mosi  <= 1'b0;
        end
      endcase
      if (w_tx_upd) begin
        r_mosi <= f_tx_bit(r_tx);
      end
      if (w_sample) begin
        r_bit <= w_word_done ? '0 : r_bit + BW'(1);
      end
    end
  end

  // Shift registers: command out, received word in, completed words into the
  // packet so that word 0 ends in the most significant slot.
  always_ff @(posedge m_clk) begin
    if (r_state == S_IDLE && start) begin
      r_tx <= cpha ? cmd : f_tx_shift(cmd);
    end else if (w_tx_upd) begin
      r_tx <= f_tx_shift(r_tx);
    end
    if (w_sample) begin
      r_word <= w_word_nxt;
      if (w_word_done) begin
        r_pkt <= (r_pkt << DATA_W) | PKT_W'(w_word_nxt);
      end
    end
  end

  // Packet storage. Contents are only meaningful through the pointers.
  always_ff @(posedge m_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= r_pkt;
    end
  end

  // FIFO pointers, status flags, sticky overflow and the host read port.
  always_ff @(posedge m_clk or negedge n_reset) begin
    if (!n_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
      r_ovf    <= 1'b0;
      r_dout   <= '0;
      r_dvalid <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_nxt;
      r_rd_ptr <= w_rd_nxt;
      r_empty  <= (w_wr_nxt == w_rd_nxt);
      r_full   <= (w_wr_nxt == {~w_rd_nxt[AW], w_rd_nxt[AW-1:0]});
      r_dvalid <= w_pop;
      if (w_pop) begin
        r_dout <= r_mem[r_rd_ptr[AW-1:0]];
      end
      if (w_push_req && !w_push) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign spi_clk      = r_clk;
  assign spi_cs       = r_cs;
  assign spi_mosi_out = r_mosi;
  assign busy         = r_busy;
  assign data_out     = r_dout;
  assign data_valid   = r_dvalid;
  assign fifo_empty   = r_empty;
  assign fifo_full    = r_full;
  assign overflow     = r_ovf;

endmodule

// File: tb/tb_spi_rx_packer.sv
// Testbench for spi_rx_packer: a behavioural SPI slave plus a packet-queue
// reference model, with randomized modes, commands and slave data.
module tb_spi_rx_packer;

  localparam int DATA_W     = 8;
  localparam int WORDS      = 15;
  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int PKT_W      = DATA_W * WORDS;
  localparam int XFER       = CLK_DIV * (2 * PKT_W + 2);

  typedef logic [PKT_W-1:0] val_t;

  logic              m_clk = 1'b0;
  logic              n_reset;
  logic              start;
  logic              cpol_i;
  logic              cpha_i;
  logic [DATA_W-1:0] cmd_i;
  logic              spi_clk;
  logic              spi_cs;
  logic              spi_mosi_out;
  logic              spi_miso_in = 1'b0;
  logic              busy;
  logic              read_req;
  logic [PKT_W-1:0]  data_out;
  logic              data_valid;
  logic              fifo_empty;
  logic              fifo_full;
  logic              overflow;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  val_t exp_q[$];
  logic exp_ovf  = 1'b0;
  val_t last_out = '0;

  // Slave model state
  logic [DATA_W-1:0] slv_w [WORDS];
  logic              tb_cpha = 1'b0;
  logic              prev_cs = 1'b1;
  logic              prev_clk = 1'b0;
  int                edge_n = 0;
  int                cs_low = 0;
  int                first_edge = -1;
  logic [PKT_W-1:0]  mosi_bits = '0;

  spi_rx_packer #(
    .DATA_W    (DATA_W),
    .WORDS     (WORDS),
    .CLK_DIV   (CLK_DIV),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .m_clk       (m_clk),
    .n_reset     (n_reset),
    .start       (start),
    .cpol        (cpol_i),
    .cpha        (cpha_i),
    .cmd         (cmd_i),
    .spi_clk     (spi_clk),
    .spi_cs      (spi_cs),
    .spi_mosi_out(spi_mosi_out),
    .spi_miso_in (spi_miso_in),
    .busy        (busy),
    .read_req    (read_req),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .fifo_empty  (fifo_empty),
    .fifo_full   (fifo_full),
    .overflow    (overflow)
  );

  always #5 m_clk = ~m_clk;

  task automatic chk(input string tag, input val_t obs, input val_t exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Bit b of the packet as the slave puts it on the wire.
  function automatic logic slave_bit(input int b);
    logic [DATA_W-1:0] w;
    int j;
    if (b >= PKT_W) return 1'b0;
    w = slv_w[b / DATA_W];
    j = b % DATA_W;
`ifdef SPI_RX_LSB_FIRST_EN
    return w[j];
`else
    return w[DATA_W-1-j];
`endif
  endfunction

  // Expected packet: words concatenated with word 0 in the MS slot.
  function automatic val_t pkt_of_words();
    val_t p;
    p = '0;
    for (int i = 0; i < WORDS; i++) p = (p << DATA_W) | val_t'(slv_w[i]);
    return p;
  endfunction

  // Slave: reacts to chip select and SPI clock edges as a real device would.
  always @(posedge m_clk) begin
    #1;
    if (prev_cs && !spi_cs) begin
      edge_n     = 0;
      cs_low     = 1;
      first_edge = -1;
      mosi_bits  = '0;
      spi_miso_in = tb_cpha ? 1'b0 : slave_bit(0);
    end else if (!spi_cs) begin
      cs_low++;
      if (spi_clk != prev_clk) begin
        int b;
        edge_n++;
        if (edge_n == 1) first_edge = cs_low - 1;
        b = (edge_n - 1) / 2;
        if (edge_n % 2 == 1) begin
          if (!tb_cpha) begin
            if (b < PKT_W) mosi_bits[b] = spi_mosi_out;
          end else begin
            spi_miso_in = slave_bit(b);
          end
        end else begin
          if (!tb_cpha) spi_miso_in = slave_bit(b + 1);
          else if (b < PKT_W) mosi_bits[b] = spi_mosi_out;
        end
      end
    end else begin
      spi_miso_in = 1'b0;
    end
    prev_cs  = spi_cs;
    prev_clk = spi_clk;
  end

  task automatic do_start(input logic cp, input logic ch, input logic [DATA_W-1:0] c);
    @(negedge m_clk);
    tb_cpha = ch;
    cpol_i  = cp;
    cpha_i  = ch;
    cmd_i   = c;
    start   = 1'b1;
    @(negedge m_clk);
    start   = 1'b0;
    chk("cs_fall_t1", val_t'(spi_cs), val_t'(1'b0));
    chk("busy_t1", val_t'(busy), val_t'(1'b1));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 2 * XFER) begin
      @(negedge m_clk);
      n++;
    end
    chk("idle_reached", val_t'(busy), val_t'(1'b0));
  endtask

  task automatic xfer(input logic cp, input logic ch, input logic [DATA_W-1:0] c,
                      input bit fixed, input bit rd_at_push);
    val_t pkt;
    val_t ex;
    logic [DATA_W-1:0] mw;
    for (int i = 0; i < WORDS; i++) slv_w[i] = fixed ? DATA_W'(i + 1) : DATA_W'($urandom);
    pkt = pkt_of_words();
    do_start(cp, ch, c);
    repeat (XFER - 1) @(negedge m_clk);
    chk("cs_last_low", val_t'(spi_cs), val_t'(1'b0));
    @(negedge m_clk);
    chk("push_cs_high", val_t'(spi_cs), val_t'(1'b1));
    chk("push_busy", val_t'(busy), val_t'(1'b1));
    if (rd_at_push && exp_q.size() > 0) begin
      read_req = 1'b1;
      @(negedge m_clk);
      read_req = 1'b0;
      ex = exp_q.pop_front();
      chk("push_rd_valid", val_t'(data_valid), val_t'(1'b1));
      chk("push_rd_data", data_out, ex);
      last_out = ex;
    end
    wait_idle();
    if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(pkt);
    else exp_ovf = 1'b1;
    mw = '0;
    for (int b = 0; b < DATA_W; b++) begin
`ifdef SPI_RX_LSB_FIRST_EN
      mw[b] = mosi_bits[b];
`else
      mw[DATA_W-1-b] = mosi_bits[b];
`endif
    end
    chk("cs_low_cycles", val_t'(cs_low), val_t'(XFER));
    chk("first_edge", val_t'(first_edge), val_t'(CLK_DIV));
    chk("edge_count", val_t'(edge_n), val_t'(2 * PKT_W));
    chk("mosi_cmd", val_t'(mw), val_t'(c));
    chk("mosi_rest_zero", val_t'(mosi_bits >> DATA_W), val_t'(0));
    chk("idle_clk_cpol", val_t'(spi_clk), val_t'(cp));
    chk("idle_mosi", val_t'(spi_mosi_out), val_t'(1'b0));
    chk("full_flag", val_t'(fifo_full), val_t'(exp_q.size() == FIFO_DEPTH));
    chk("empty_flag", val_t'(fifo_empty), val_t'(exp_q.size() == 0));
    chk("overflow", val_t'(overflow), val_t'(exp_ovf));
  endtask

  // Back-to-back reads, one per cycle, checked against the model queue.
  task automatic rd_burst(input int n);
    val_t ex;
    @(negedge m_clk);
    read_req = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge m_clk);
      if (i == n - 1) read_req = 1'b0;
      if (exp_q.size() > 0) begin
        ex = exp_q.pop_front();
        chk("rd_valid", val_t'(data_valid), val_t'(1'b1));
        chk("rd_data", data_out, ex);
        last_out = ex;
      end else begin
        chk("rd_empty_novalid", val_t'(data_valid), val_t'(1'b0));
        chk("rd_empty_hold", data_out, last_out);
      end
    end
    @(negedge m_clk);
    chk("valid_drop", val_t'(data_valid), val_t'(1'b0));
    chk("empty_after_rd", val_t'(fifo_empty), val_t'(exp_q.size() == 0));
  endtask

  initial begin
    n_reset  = 1'b0;
    start    = 1'b0;
    read_req = 1'b0;
    cpol_i   = 1'b0;
    cpha_i   = 1'b0;
    cmd_i    = '0;
    repeat (3) @(negedge m_clk);
    chk("rst_cs", val_t'(spi_cs), val_t'(1'b1));
    chk("rst_clk", val_t'(spi_clk), val_t'(1'b0));
    chk("rst_mosi", val_t'(spi_mosi_out), val_t'(1'b0));
    chk("rst_busy", val_t'(busy), val_t'(1'b0));
    chk("rst_dout", data_out, val_t'(0));
    chk("rst_dvalid", val_t'(data_valid), val_t'(1'b0));
    chk("rst_empty", val_t'(fifo_empty), val_t'(1'b1));
    chk("rst_full", val_t'(fifo_full), val_t'(1'b0));
    chk("rst_ovf", val_t'(overflow), val_t'(1'b0));
    n_reset = 1'b1;

    // Mode 0, counting slave pattern
    xfer(1'b0, 1'b0, 8'hA5, 1'b1, 1'b0);
    rd_burst(1);
    begin
      val_t ref_pat;
      ref_pat = 120'h0102030405060708090A0B0C0D0E0F;
      chk("mode0_pattern", data_out, ref_pat);
    end

    // Modes 1..3 with the same slave pattern
    for (int m = 1; m < 4; m++) begin
      logic [1:0] md;
      md = 2'(m);
      xfer(md[1], md[0], 8'hA5, 1'b1, 1'b0);
      rd_burst(1);
    end

    // Fill the FIFO, pop during a push while full, then overflow
    for (int k = 0; k < 4; k++)
      xfer(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), DATA_W'($urandom), 1'b0, 1'b0);
    xfer(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), DATA_W'($urandom), 1'b0, 1'b1);
    xfer(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), DATA_W'($urandom), 1'b0, 1'b0);
    rd_burst(4);
    rd_burst(1);

    // Asynchronous reset in the middle of a transfer
    xfer(1'b1, 1'b1, DATA_W'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < WORDS; i++) slv_w[i] = DATA_W'($urandom);
    do_start(1'b0, 1'b1, DATA_W'($urandom));
    repeat (300) @(negedge m_clk);
    n_reset = 1'b0;
    #1;
    chk("mid_rst_cs", val_t'(spi_cs), val_t'(1'b1));
    chk("mid_rst_busy", val_t'(busy), val_t'(1'b0));
    chk("mid_rst_empty", val_t'(fifo_empty), val_t'(1'b1));
    chk("mid_rst_ovf", val_t'(overflow), val_t'(1'b0));
    chk("mid_rst_dout", data_out, val_t'(0));
    exp_q.delete();
    exp_ovf  = 1'b0;
    last_out = '0;
    @(negedge m_clk);
    n_reset = 1'b1;
    xfer(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), DATA_W'($urandom), 1'b0, 1'b0);
    rd_burst(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
